// File: rtl/l5_result_uart_tx.sv
// Result UART transmitter: sends the class index as an ASCII digit followed by CR LF (8N1, LSB first),
// then pulses tx_done so the upstream layer can release its result.
module l5_result_uart_tx #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd,
   input  logic [7:0] din,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [W-1:0] BAUD_LAST = W'(BAUD_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]   r_state;
   logic         r_rd_q;
   logic [3:0]   r_idx;
   logic [W-1:0] r_baud_cnt;
   logic [2:0]   r_bit_cnt;
   logic [1:0]   r_byte_idx;
   logic         r_tx;
   logic         r_tx_done;

   logic         w_trigger;
   logic         w_bit_end;
   logic [7:0]   w_byte0;
   logic [7:0]   w_cur_byte;
   logic         w_unused_din;

   assign w_trigger    = (r_state == S_IDLE) && rd && !r_rd_q;
   assign w_bit_end    = (r_baud_cnt == BAUD_LAST);
   assign w_byte0      = (r_idx <= 4'd9) ? {4'h3, r_idx} : 8'h3F;
   assign w_unused_din = ^din[7:4];

   always_comb begin
      w_cur_byte = w_byte0;
      case (r_byte_idx)
         2'd1:    w_cur_byte = 8'h0D;
         2'd2:    w_cur_byte = 8'h0A;
         default: w_cur_byte = w_byte0;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rd_q     <= 1'b0;
         r_idx      <= 4'd0;
         r_baud_cnt <= '0;
         r_bit_cnt  <= 3'd0;
         r_byte_idx <= 2'd0;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
      end else begin
         r_rd_q <= rd;
         // tx only ever changes on a bit boundary, so the line is glitch-free
         case (r_state)
            S_IDLE: begin
               r_tx      <= 1'b1;
               r_tx_done <= 1'b0;
               if (w_trigger) begin
                  r_idx      <= din[3:0];
                  r_baud_cnt <= '0;
                  r_byte_idx <= 2'd0;
                  r_tx       <= 1'b0;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= 3'd0;
                  r_tx       <= w_cur_byte[0];
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + W'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_cnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_tx      <= w_cur_byte[r_bit_cnt + 3'd1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + W'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (r_byte_idx < 2'd2) begin
                     r_byte_idx <= r_byte_idx + 2'd1;
                     r_tx       <= 1'b0;
                     r_state    <= S_START;
                  end else begin
                     r_tx      <= 1'b1;
                     r_tx_done <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + W'(1);
               end
            end
            S_DONE: begin
               r_tx      <= 1'b1;
               r_tx_done <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_tx      <= 1'b1;
               r_tx_done <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign tx      = r_tx;
   assign busy    = (r_state != S_IDLE);
   assign tx_done = r_tx_done;

endmodule

// File: tb/tb_l5_result_uart_tx.sv
// Directed bench for l5_result_uart_tx: a BAUD_DIV=4 instance for the functional and boundary tests,
// and a BAUD_DIV=434 instance for the full-rate smoke test.
module tb_l5_result_uart_tx;

   logic       clk;
   logic       rst;
   logic       rd4, rd434;
   logic [7:0] din4, din434;
   logic       tx4, busy4, done4;
   logic       tx434, busy434, done434;

   int n_checks = 0;
   int n_errors = 0;

   l5_result_uart_tx #(.BAUD_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .rd(rd4), .din(din4),
      .tx(tx4), .busy(busy4), .tx_done(done4)
   );

   l5_result_uart_tx #(.BAUD_DIV(434)) u_dut434 (
      .clk(clk), .rst(rst), .rd(rd434), .din(din434),
      .tx(tx434), .busy(busy434), .tx_done(done434)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Raises rd, then checks {tx,busy,tx_done} on every cycle of the frame.
   // perturb wiggles din/rd mid-frame; abort_k >= 0 asserts rst after checking cycle abort_k.
   task automatic frame(input bit big, input logic [7:0] d, input logic [7:0] b0,
                        input bit perturb, input int abort_k);
      int         bd;
      int         n;
      int         j;
      logic [7:0] bytes [3];
      logic       ebit;
      logic [2:0] exp;
      logic [2:0] obs;
      bd       = big ? 434 : 4;
      bytes[0] = b0;
      bytes[1] = 8'h0D;
      bytes[2] = 8'h0A;
      rst      = 1'b0;
      if (big) begin
         din434 = d;
         rd434  = 1'b1;
      end else begin
         din4 = d;
         rd4  = 1'b1;
      end
      for (int k = 0; k <= 30 * bd + 1; k++) begin
         @(negedge clk);
         if (k < 30 * bd) begin
            n = k / bd;
            j = n % 10;
            if (j == 0)      ebit = 1'b0;
            else if (j == 9) ebit = 1'b1;
            else             ebit = bytes[n / 10][j - 1];
            exp = {ebit, 1'b1, 1'b0};
         end else if (k == 30 * bd) begin
            exp = 3'b111;
         end else begin
            exp = 3'b100;
         end
         obs = big ? {tx434, busy434, done434} : {tx4, busy4, done4};
         check($sformatf("frame din=%h k=%0d", d, k), {5'd0, obs}, {5'd0, exp});
         if (perturb && !big) begin
            case (k)
               5:  din4 = 8'h05;
               10: rd4  = 1'b0;
               30: rd4  = 1'b1;
               40: din4 = 8'h09;
               default: ;
            endcase
         end
         if (k == abort_k) begin
            rst = 1'b1;
            rd4 = 1'b0;
            return;
         end
      end
   endtask

   task automatic idle_gap;
      rd4 = 1'b0;
      @(negedge clk);
      check("idle_gap", {5'd0, tx4, busy4, done4}, 8'h04);
   endtask

   initial begin
      rst    = 1'b1;
      rd4    = 1'b0;
      rd434  = 1'b1;
      din4   = 8'h00;
      din434 = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_4",   {5'd0, tx4, busy4, done4},       8'h04);
      check("reset_434", {5'd0, tx434, busy434, done434}, 8'h04);

      // Full-rate smoke test; rd434 is held high across reset release, which counts as the edge
      frame(1'b1, 8'h00, 8'h30, 1'b0, -1);
      rd434 = 1'b0;

      // Basic frame and the digit mapping
      frame(1'b0, 8'h07, 8'h37, 1'b0, -1);
      idle_gap();
      frame(1'b0, 8'h0C, 8'h3F, 1'b0, -1);
      idle_gap();
      frame(1'b0, 8'hF3, 8'h33, 1'b0, -1);

      // rd held after tx_done must not retrigger
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         check($sformatf("hold_rd i=%0d", i), {5'd0, tx4, busy4, done4}, 8'h04);
      end
      idle_gap();
      frame(1'b0, 8'h41, 8'h31, 1'b0, -1);

      // Reset during DATA bit 3 of byte1 (cycles 56..59 at BAUD_DIV=4)
      idle_gap();
      frame(1'b0, 8'h08, 8'h38, 1'b0, 57);
      @(negedge clk);
      check("abort_next", {5'd0, tx4, busy4, done4}, 8'h04);
      rst = 1'b0;
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         check($sformatf("abort_quiet i=%0d", i), {5'd0, tx4, busy4, done4}, 8'h04);
      end
      frame(1'b0, 8'h02, 8'h32, 1'b0, -1);

      // rst and the trigger edge in the same cycle: reset wins, the held rd triggers afterwards
      idle_gap();
      rst  = 1'b1;
      rd4  = 1'b1;
      din4 = 8'h04;
      @(negedge clk);
      check("rst_vs_trigger", {5'd0, tx4, busy4, done4}, 8'h04);
      frame(1'b0, 8'h04, 8'h34, 1'b0, -1);

      // din and rd wiggle mid-frame; the latched digit is sent and tx_done pulses once
      idle_gap();
      frame(1'b0, 8'h06, 8'h36, 1'b1, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
